vga_scanout: RTL
================

Name: vga_scanout

Overview:
- Display-side reader for the 320x240, 6-bit-colour frame buffer written by the pixel generators. Plotters write pixels into this buffer; this block reads them back.
- Generates standard 640x480@60 VGA timing from the 50 MHz clock.
- Issues frame-buffer read addresses with 2x2 pixel doubling.
- Registers the returned colour and drives the DAC pins: R/G/B, HS, VS, BLANK_N, SYNC_N and CLK.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- FB_WIDTH, 320, frame-buffer pixels per row

Ports:
- clock  in  1  50 MHz system clock
- reset  in  1  synchronous, active-high reset
- rd_addr  out  17  frame-buffer read address, y*FB_WIDTH+x
- rd_data  in  6  frame-buffer data, 1-clock read latency; [5:4] R, [3:2] G, [1:0] B
- frame_start  out  1  one-clock pulse at start of each frame
- VGA_CLK  out  1  25 MHz pixel clock
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_BLANK_N  out  1  high during the visible region
- VGA_SYNC_N  out  1  constant 1
- VGA_R  out  10  red DAC value
- VGA_G  out  10  green DAC value
- VGA_B  out  10  blue DAC value

Behaviour:
- **Interface:** one clock (`clock`); `reset` is synchronous and active-high. Everything below is sampled on posedge `clock`.
- **Pixel tick:**
  - `pix_en` toggles every clock, so a pixel tick occurs every second clock.
  - VGA_CLK = registered toggle, high during the clock in which `pix_en` is 1.
- **Counters:**
  - `hcount` runs 0..799 (H_TOTAL = sum of the H_* parameters).
  - `vcount` runs 0..524.
  - Both advance only on a pixel tick. `hcount` wraps 799->0; `vcount` increments on that wrap and wraps 524->0.
- **Horizontal state machine** (a decode of `hcount`):
  - ACTIVE: 0..639
  - FRONT: 640..655
  - SYNC: 656..751
  - BACK: 752..799
- **Vertical state machine**, same decode on `vcount`:
  - ACTIVE: 0..479
  - FRONT: 480..489
  - SYNC: 490..491
  - BACK: 492..524
- **Stage 1** (registered on a pixel tick, from the counters):
  - `rd_addr = (vcount>>1)*320 + (hcount>>1)`, implemented as shifts and adds (no multiplier).
  - `rd_addr = 0` when outside the active region.
  - Stage-1 hs/vs/active flags are registered alongside.
- **Stage 2** (next pixel tick):
  - Colour register samples `rd_data`, which is valid because RAM latency of 1 clock < 2 clocks.
  - HS, VS and BLANK_N take the stage-1 flags.
  - All pins are mutually aligned; pins lag the counters by exactly 2 pixel ticks.
- **Colour expansion:**
  - Each 2-bit channel `c` is replicated 5 times into 10 bits: 00->0x000, 01->0x155, 10->0x2AA, 11->0x3FF.
  - R/G/B are forced to 0 whenever BLANK_N=0.
- **frame_start:** one-clock pulse on the pixel tick where the counters wrap (799,524)->(0,0).
- **Reset values:**
  - hcount=0, vcount=0, pix_en=0, VGA_CLK=0
  - rd_addr=0, frame_start=0
  - VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, RGB=0
  - VGA_SYNC_N=1 (always)
- **Reset mid-frame:** all state returns to the reset values on the next edge. Scan restarts at (0,0) with no partial-line artefacts; the first output pixel appears 2 pixel ticks after reset deasserts.
- **Address range:** max `rd_addr` = 239*320+319 = 76799; never exceeds it.

Optional Feature:
- Macro: `VGA_TEST_PATTERN_EN`.
- **Defined:**
  - Adds input port `test_mode` (1 bit).
  - When `test_mode`=1, stage 2 ignores `rd_data`. It shows 8 vertical bars, each 40 frame-buffer columns wide.
  - Bar index `b` = `(hcount>>1)/40`, taken from stage 1. Colour bits {R,G,B} = {b[2],b[2],b[1],b[1],b[0],b[0]}.
  - `rd_addr` still toggles normally; timing is unchanged.
- **Undefined:** no `test_mode` port; colour always comes from `rd_data`.

Test Plan:
- Reset held 3 clocks then released -> during reset HS=1, VS=1, BLANK_N=0, RGB=0, rd_addr=0. After release VGA_CLK period = 2 clocks.
- Free run 1 line -> HS low for 192 clocks, HS period 1600 clocks, BLANK_N high for 1280 clocks per line.
- Free run 2 frames -> VS low for 3200 clocks, VS period 840000 clocks, frame_start pulses exactly 840000 clocks apart, 1 clock wide.
- Address mapping -> counters (h=3,v=5) yield rd_addr=641; (639,479) yield 76799; blanking yields 0.
- Colour path, RAM model with 1-clock latency returning 6'b110100 -> R=0x3FF, G=0x155, B=0x000. RGB=0 during the porches; colour appears 2 pixel ticks after its address.
- Reset asserted at h=400, v=200 -> next clock counters are at 0,0 and outputs are at reset values. Timing from release matches the first scenario exactly.

Source files
------------

// File: rtl/vga_scanout_if.sv
// Frame-buffer read port between vga_scanout (master) and the frame-buffer RAM (slave),
// plus read-only taps of the horizontal/vertical scan state.
interface vga_scanout_if;
  // Fixed-latency read, no valid/ready: rd_addr is a registered output that changes only
  // on a pixel tick. The RAM returns rd_data for it one clock later, and the scanout
  // samples rd_data on the following pixel tick, two clocks after the address changed.
  logic [16:0] rd_addr;
  logic [5:0]  rd_data;
  logic [1:0]  dbg_hstate;
  logic [1:0]  dbg_vstate;

  modport master (output rd_addr, input rd_data, output dbg_hstate, output dbg_vstate);
  modport slave  (input rd_addr, output rd_data, input dbg_hstate, input dbg_vstate);
endinterface

// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout of a 320x240x6-bit frame buffer with 2x2 pixel doubling.
// Optional colour-bar source when built with VGA_TEST_PATTERN_EN.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int FB_WIDTH = 320
) (
  input  logic                 clock,
  input  logic                 reset,
  vga_scanout_if.master        fb,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                 test_mode,
`endif
  output logic                 frame_start,
  output logic                 VGA_CLK,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic                 VGA_BLANK_N,
  output logic                 VGA_SYNC_N,
  output logic [9:0]           VGA_R,
  output logic [9:0]           VGA_G,
  output logic [9:0]           VGA_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_FRONT_BEG  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG   = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] H_BACK_BEG   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_FRONT_BEG  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG   = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] V_BACK_BEG   = VW'(V_ACTIVE + V_FRONT + V_SYNC);

  typedef enum logic [1:0] {ST_ACTIVE, ST_FRONT, ST_SYNC, ST_BACK} scan_state_e;

  logic          pix_en_q, pix_en_d;
  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic [16:0]   rd_addr_q, rd_addr_d;
  logic          hs1_q, hs1_d, vs1_q, vs1_d, act1_q, act1_d;
  logic          hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic [5:0]    color_q, color_d;
  logic          frame_start_q, frame_start_d;

  scan_state_e   hstate, vstate;
  logic          active;
  logic [HW-2:0] fb_x;
  logic [VW-2:0] fb_y;
  logic [16:0]   row_base;
  logic [5:0]    pixel_src;

  // The scan "state machines" are pure decodes of the counters, which are the state.
  always_comb begin
    hstate = ST_BACK;
    if (hcount_q < H_FRONT_BEG)     hstate = ST_ACTIVE;
    else if (hcount_q < H_SYNC_BEG) hstate = ST_FRONT;
    else if (hcount_q < H_BACK_BEG) hstate = ST_SYNC;
  end

  always_comb begin
    vstate = ST_BACK;
    if (vcount_q < V_FRONT_BEG)     vstate = ST_ACTIVE;
    else if (vcount_q < V_SYNC_BEG) vstate = ST_FRONT;
    else if (vcount_q < V_BACK_BEG) vstate = ST_SYNC;
  end

  assign active = (hstate == ST_ACTIVE) && (vstate == ST_ACTIVE);
  assign fb_x   = hcount_q[HW-1:1];
  assign fb_y   = vcount_q[VW-1:1];

  // Row base = fb_y * FB_WIDTH as a sum of shifted copies, one per set bit of FB_WIDTH.
  always_comb begin
    row_base = '0;
    for (int i = 0; i < 17; i++) begin
      if (FB_WIDTH[i]) row_base = row_base + (17'(fb_y) << i);
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar, bar1_q;

  always_comb begin
    bar = '0;
    for (int i = 1; i < 8; i++) begin
      if (fb_x >= (HW-1)'(i * 40)) bar = 3'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset)         bar1_q <= '0;
    else if (pix_en_q) bar1_q <= bar;
  end

  assign pixel_src = test_mode ? {bar1_q[2], bar1_q[2], bar1_q[1], bar1_q[1], bar1_q[0], bar1_q[0]}
                               : fb.rd_data;
`else
  assign pixel_src = fb.rd_data;
`endif

  always_comb begin
    pix_en_d      = ~pix_en_q;
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    frame_start_d = 1'b0;
    rd_addr_d     = rd_addr_q;
    hs1_d         = hs1_q;
    vs1_d         = vs1_q;
    act1_d        = act1_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    blank_n_d     = blank_n_q;
    color_d       = color_q;
    if (pix_en_q) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        if (vcount_q == V_LAST) begin
          vcount_d      = '0;
          frame_start_d = 1'b1;
        end else begin
          vcount_d = vcount_q + VW'(1);
        end
      end else begin
        hcount_d = hcount_q + HW'(1);
      end
      rd_addr_d = active ? (row_base + 17'(fb_x)) : '0;
      hs1_d     = (hstate != ST_SYNC);
      vs1_d     = (vstate != ST_SYNC);
      act1_d    = active;
      // Stage 2: rd_data now answers the address stage 1 issued one tick ago.
      hs_d      = hs1_q;
      vs_d      = vs1_q;
      blank_n_d = act1_q;
      color_d   = act1_q ? pixel_src : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pix_en_q      <= 1'b0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      frame_start_q <= 1'b0;
      rd_addr_q     <= '0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      act1_q        <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      color_q       <= '0;
    end else begin
      pix_en_q      <= pix_en_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      frame_start_q <= frame_start_d;
      rd_addr_q     <= rd_addr_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      act1_q        <= act1_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      color_q       <= color_d;
    end
  end

  assign fb.rd_addr    = rd_addr_q;
  assign fb.dbg_hstate = hstate;
  assign fb.dbg_vstate = vstate;
  assign frame_start   = frame_start_q;
  assign VGA_CLK       = pix_en_q;
  assign VGA_HS        = hs_q;
  assign VGA_VS        = vs_q;
  assign VGA_BLANK_N   = blank_n_q;
  assign VGA_SYNC_N    = 1'b1;
  assign VGA_R         = {5{color_q[5:4]}};
  assign VGA_G         = {5{color_q[3:2]}};
  assign VGA_B         = {5{color_q[1:0]}};

endmodule
